// File: rtl/gremlin_pkg.sv
// Shared constants and animation state encoding for the gremlin sprite stage.
// Sprite geometry, coordinate widths and colour width live here.
package gremlin_pkg;

  localparam int SPRITE_W = 16;
  localparam int SPRITE_H = 32;
  localparam int LINE_AW  = 5;
  localparam int COL_AW   = 4;
  localparam int HC_W     = 11;
  localparam int RGB_W    = 12;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    F0   = 2'd1,
    F1   = 2'd2
  } anim_state_t;

endpackage

// File: rtl/gremlin_anim.sv
// Walking animation: vsync edge detect, display-frame counter, frame FSM.
// The frame bit only moves on vsync rising edges; dropping walk forces HOLD.
module gremlin_anim
  import gremlin_pkg::*;
#(
  parameter int ANIM_PERIOD = 8
) (
  input  logic pclk,
  input  logic rst_n,
  input  logic vsync_in,
  input  logic walk,
  output logic frame
);

  anim_state_t state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        vs_q;
  logic        vs_edge;
  logic        last;
  logic        go_hold, go_start, go_wrap, go_inc;

  assign vs_edge = vsync_in & ~vs_q;
  assign last    = (cnt == 8'(ANIM_PERIOD - 1));

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HOLD;
      cnt   <= '0;
      vs_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      vs_q  <= vsync_in;
    end
  end

  // Conditions kept mutually exclusive; walk=0 beats a coincident edge.
  assign go_hold  = ~walk;
  assign go_start = walk & (state == HOLD);
  assign go_wrap  = walk & (state != HOLD)
                  & vs_edge & last;
  assign go_inc   = walk & (state != HOLD)
                  & vs_edge & ~last;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (1'b1)
      go_hold: begin
        state_nxt = HOLD;
        cnt_nxt   = '0;
      end
      go_start: begin
        state_nxt = F0;
        cnt_nxt   = '0;
      end
      go_wrap: begin
        state_nxt = (state == F1) ? F0 : F1;
        cnt_nxt   = '0;
      end
      go_inc: begin
        cnt_nxt = cnt + 8'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    frame = (state == F1);
  end

endmodule

// File: rtl/gremlin_draw.sv
// Gremlin sprite overlay stage: 2-cycle pipeline over the VGA stream.
// Optional horizontal mirror port with GREMLIN_MIRROR_EN.
module gremlin_draw
  import gremlin_pkg::*;
#(
  parameter logic [RGB_W-1:0] SPRITE_COLOR = 12'hF00,
  parameter int               ANIM_PERIOD  = 8
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic [HC_W-1:0]   hcount_in,
  input  logic [HC_W-1:0]   vcount_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              hblnk_in,
  input  logic              vblnk_in,
  input  logic [RGB_W-1:0]  rgb_in,
  input  logic [HC_W-1:0]   xpos,
  input  logic [HC_W-1:0]   ypos,
  input  logic              walk,
`ifdef GREMLIN_MIRROR_EN
  input  logic              mirror,
`endif
  output logic              rom_frame,
  output logic [LINE_AW-1:0] rom_line,
  input  logic [SPRITE_W-1:0] rom_pixels,
  output logic [HC_W-1:0]   hcount_out,
  output logic [HC_W-1:0]   vcount_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              hblnk_out,
  output logic              vblnk_out,
  output logic [RGB_W-1:0]  rgb_out
);

  logic [HC_W-1:0]   x_l, y_l;
  logic [HC_W-1:0]   hc1, vc1;
  logic              hs1, vs1, hb1, vb1;
  logic [RGB_W-1:0]  rgb1;
  logic              box1;
  logic [COL_AW-1:0] col1;
  logic              in_box;
  logic [HC_W:0]     h12, v12, x12, y12;
  logic [COL_AW-1:0] dh;
  logic [LINE_AW-1:0] dv;
  logic              pix_bit;
  logic [RGB_W-1:0]  rgb_nxt;
`ifdef GREMLIN_MIRROR_EN
  logic              mir1;
`endif

  gremlin_anim #(
    .ANIM_PERIOD(ANIM_PERIOD)
  ) u_anim (
    .pclk    (pclk),
    .rst_n   (rst_n),
    .vsync_in(vsync_in),
    .walk    (walk),
    .frame   (rom_frame)
  );

  // One extra bit so x_l+16 / y_l+32 cannot wrap.
  assign h12 = {1'b0, hcount_in};
  assign v12 = {1'b0, vcount_in};
  assign x12 = {1'b0, x_l};
  assign y12 = {1'b0, y_l};

  assign in_box = (h12 >= x12)
                & (h12 < x12 + 12'(SPRITE_W))
                & (v12 >= y12)
                & (v12 < y12 + 12'(SPRITE_H));

  assign dh = hcount_in[COL_AW-1:0]
            - x_l[COL_AW-1:0];
  assign dv = vcount_in[LINE_AW-1:0]
            - y_l[LINE_AW-1:0];

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      x_l      <= '0;
      y_l      <= '0;
      hc1      <= '0;
      vc1      <= '0;
      hs1      <= 1'b0;
      vs1      <= 1'b0;
      hb1      <= 1'b0;
      vb1      <= 1'b0;
      rgb1     <= '0;
      box1     <= 1'b0;
      col1     <= '0;
      rom_line <= '0;
`ifdef GREMLIN_MIRROR_EN
      mir1     <= 1'b0;
`endif
    end else begin
      // vb1 is the registered vblnk_in used for the edge detect.
      if (vblnk_in && !vb1) begin
        x_l <= xpos;
        y_l <= ypos;
      end
      hc1      <= hcount_in;
      vc1      <= vcount_in;
      hs1      <= hsync_in;
      vs1      <= vsync_in;
      hb1      <= hblnk_in;
      vb1      <= vblnk_in;
      rgb1     <= rgb_in;
      box1     <= in_box;
      col1     <= in_box ? dh : '0;
      rom_line <= in_box ? dv : '0;
`ifdef GREMLIN_MIRROR_EN
      mir1     <= mirror;
`endif
    end
  end

`ifdef GREMLIN_MIRROR_EN
  assign pix_bit = mir1
                 ? rom_pixels[col1]
                 : rom_pixels[4'(SPRITE_W-1) - col1];
`else
  assign pix_bit = rom_pixels[4'(SPRITE_W-1) - col1];
`endif

  always_comb begin
    rgb_nxt = rgb1;
    if (hb1 || vb1) begin
      rgb_nxt = '0;
    end else if (box1 && pix_bit) begin
      rgb_nxt = SPRITE_COLOR;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= hc1;
      vcount_out <= vc1;
      hsync_out  <= hs1;
      vsync_out  <= vs1;
      hblnk_out  <= hb1;
      vblnk_out  <= vb1;
      rgb_out    <= rgb_nxt;
    end
  end

endmodule

// File: tb/tb_gremlin_draw.sv
// Self-checking bench for gremlin_draw against a behavioural pixel model.
module tb_gremlin_draw;
  import gremlin_pkg::*;

  localparam int P = 2;
  localparam logic [11:0] COLOR = 12'hF00;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 0, vsync_in = 0;
  logic        hblnk_in = 0, vblnk_in = 0;
  logic [11:0] rgb_in = '0;
  logic [10:0] xpos = '0, ypos = '0;
  logic        walk = 0;
  logic        mirror = 0;
  logic        rom_frame;
  logic [4:0]  rom_line;
  logic [15:0] rom_pixels;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  gremlin_draw #(
    .SPRITE_COLOR(COLOR),
    .ANIM_PERIOD (P)
  ) dut (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .hcount_in (hcount_in),
    .vcount_in (vcount_in),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .hblnk_in  (hblnk_in),
    .vblnk_in  (vblnk_in),
    .rgb_in    (rgb_in),
    .xpos      (xpos),
    .ypos      (ypos),
    .walk      (walk),
`ifdef GREMLIN_MIRROR_EN
    .mirror    (mirror),
`endif
    .rom_frame (rom_frame),
    .rom_line  (rom_line),
    .rom_pixels(rom_pixels),
    .hcount_out(hcount_out),
    .vcount_out(vcount_out),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out),
    .hblnk_out (hblnk_out),
    .vblnk_out (vblnk_out),
    .rgb_out   (rgb_out)
  );

  always #5 pclk = ~pclk;

  logic [15:0] rom_mem [0:63];
  assign rom_pixels = rom_mem[{rom_frame, rom_line}];

  typedef struct packed {
    logic [10:0] h, v;
    logic hs, vs, hb, vb;
    logic [11:0] rgb;
    logic signed [7:0] tag;
  } exp_t;

  exp_t q[$];
  int total = 0, passed = 0, fails = 0;
  int xl_m, yl_m, edges;
  bit prev_vb, prev_vs, walking;
  logic [15:0] cap;
  logic seq [6];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    xl_m = 0; yl_m = 0; edges = 0;
    prev_vb = 0; prev_vs = 0; walking = 0;
    q.delete();
  endtask

  task automatic step(input int h, input int v,
                      input bit hs, input bit vs,
                      input bit hb, input bit vb,
                      input logic [11:0] rgb,
                      input int tag = -1);
    exp_t e, e0;
    int xl_use, yl_use, px, py, fr, lexp, idx;
    bit inb, mir_eff;
    logic [15:0] word;
    hcount_in = 11'(h); vcount_in = 11'(v);
    hsync_in = hs; vsync_in = vs;
    hblnk_in = hb; vblnk_in = vb;
    rgb_in = rgb;
`ifdef GREMLIN_MIRROR_EN
    mir_eff = mirror;
`else
    mir_eff = 0;
`endif
    xl_use = xl_m; yl_use = yl_m;
    if (!walk) begin
      walking = 0; edges = 0;
    end else if (!walking) begin
      walking = 1; edges = 0;
    end else if (vs && !prev_vs) begin
      edges++;
    end
    prev_vs = vs;
    fr = walking ? (edges / P) % 2 : 0;
    px = h - xl_use;
    py = v - yl_use;
    inb = px >= 0 && px < 16 && py >= 0 && py < 32;
    lexp = inb ? py : 0;
    e.h = 11'(h); e.v = 11'(v);
    e.hs = hs; e.vs = vs; e.hb = hb; e.vb = vb;
    e.tag = 8'(tag);
    if (hb || vb) e.rgb = '0;
    else begin
      e.rgb = rgb;
      if (inb) begin
        word = rom_mem[fr * 32 + py];
        idx = mir_eff ? px : 15 - px;
        if (word[idx]) e.rgb = COLOR;
      end
    end
    if (vb && !prev_vb) begin
      xl_m = int'(xpos); yl_m = int'(ypos);
    end
    prev_vb = vb;
    q.push_back(e);
    @(posedge pclk); #1;
    chk("rom_frame", 32'(rom_frame), 32'(fr));
    chk("rom_line", 32'(rom_line), 32'(lexp));
    if (q.size() >= 2) begin
      e0 = q.pop_front();
      chk("hcount_out", 32'(hcount_out), 32'(e0.h));
      chk("vcount_out", 32'(vcount_out), 32'(e0.v));
      chk("syncs", {28'd0, hsync_out, vsync_out,
                    hblnk_out, vblnk_out},
          {28'd0, e0.hs, e0.vs, e0.hb, e0.vb});
      chk("rgb_out", 32'(rgb_out), 32'(e0.rgb));
      if (e0.tag >= 0)
        cap[15 - int'(e0.tag)] = (rgb_out === COLOR);
    end
  endtask

  task automatic flush();
    step(2000, 2000, 0, 0, 0, 0, 12'h123);
    step(2000, 2000, 0, 0, 0, 0, 12'h321);
  endtask

  task automatic latch(input int x, input int y);
    xpos = 11'(x); ypos = 11'(y);
    step(0, 800, 0, 0, 0, 0, 12'h0);
    step(0, 800, 0, 0, 0, 1, 12'h0);
    step(0, 801, 0, 0, 0, 0, 12'h0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_tim"}, {hcount_out, vcount_out,
        hsync_out, vsync_out, hblnk_out, vblnk_out}, 32'd0);
    chk({tag, "_rgb"}, 32'(rgb_out), 32'd0);
    chk({tag, "_rom"}, {26'd0, rom_frame, rom_line}, 32'd0);
  endtask

  task automatic rand_in();
    hcount_in = 11'($urandom); vcount_in = 11'($urandom);
    {hsync_in, vsync_in, hblnk_in, vblnk_in} = 4'($urandom);
    rgb_in = 12'($urandom); walk = 1'($urandom);
    xpos = 11'($urandom); ypos = 11'($urandom);
  endtask

  initial begin
    int h, v;
    seq = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 64; i++) rom_mem[i] = 16'($urandom);
    rom_mem[13] = 16'b1101111111111110;
    rom_mem[32 + 12] = 16'b0001111111111011;
    model_reset();

    // Reset with random inputs
    for (int i = 0; i < 5; i++) begin
      rand_in();
      @(posedge pclk); #1;
      check_zero("reset");
    end
    walk = 0; xpos = 0; ypos = 0;
    @(negedge pclk); rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++)
      step(500 + i, 500, 0, 0, 0, 0, 12'h0A0);

    // Sprite row at (100,50), frame 0
    latch(100, 50);
    cap = '0;
    for (int hh = 98; hh <= 117; hh++)
      step(hh, 63, 0, 0, 0, 0, 12'h0A0,
           (hh >= 100 && hh <= 115) ? hh - 100 : -1);
    flush();
    chk("row_frame0", 32'(cap), 32'(16'b1101111111111110));

    for (int i = 0; i < 120; i++)
      step($urandom_range(90, 125), $urandom_range(40, 90),
           1'($urandom), 0, ($urandom_range(0, 15) == 0),
           0, 12'($urandom));

    // Bottom-right clipping, no wrap at 0
    latch(1020, 760);
    for (int vv = 756; vv <= 771; vv++) begin
      v = vv % 768;
      for (int hh = 1016; hh <= 1027; hh++) begin
        h = hh % 1024;
        step(h, v, 0, 0, 0, 0, 12'($urandom));
      end
    end

    // Position change mid-frame
    latch(100, 50);
    step(100, 50, 0, 0, 0, 0, 12'h0A0);
    xpos = 11'd300;
    for (int i = 0; i < 16; i++) begin
      step(100 + i, 51, 0, 0, 0, 0, 12'h0A0);
      step(300 + i, 51, 0, 0, 0, 0, 12'h0A0);
    end
    step(0, 768, 0, 0, 0, 1, 12'h0);
    step(0, 769, 0, 0, 0, 0, 12'h0);
    for (int i = 0; i < 16; i++) begin
      step(300 + i, 51, 0, 0, 0, 0, 12'h0A0);
      step(100 + i, 51, 0, 0, 0, 0, 12'h0A0);
    end

    // Animation sequence with ANIM_PERIOD=2
    step(10, 10, 0, 0, 0, 0, 12'h0);
    walk = 1;
    step(10, 10, 0, 0, 0, 0, 12'h0);
    for (int e = 0; e < 6; e++) begin
      step(300 + e, 60, 0, 1, 0, 0, 12'h0A0);
      chk("anim_seq", 32'(rom_frame), 32'(seq[e]));
      for (int k = 0; k < 3; k++)
        step(300 + k * 5, 55 + e, 0, 0, 0, 0, 12'h0A0);
    end
    walk = 0;
    step(10, 10, 0, 1, 0, 0, 12'h0);
    chk("walk_drop", 32'(rom_frame), 32'd0);
    for (int e = 0; e < 3; e++) begin
      step(10, 10, 0, 0, 0, 0, 12'h0);
      step(10, 10, 0, 1, 0, 0, 12'h0);
    end
    chk("hold_stays", 32'(rom_frame), 32'd0);

`ifdef GREMLIN_MIRROR_EN
    walk = 1;
    step(10, 10, 0, 0, 0, 0, 12'h0);
    for (int e = 0; e < 2; e++) begin
      step(10, 10, 0, 1, 0, 0, 12'h0);
      step(10, 10, 0, 0, 0, 0, 12'h0);
    end
    latch(200, 100);
    mirror = 1;
    cap = '0;
    for (int hh = 200; hh <= 215; hh++)
      step(hh, 112, 0, 0, 0, 0, 12'h0A0, hh - 200);
    flush();
    chk("row_mirror", 32'(cap), 32'(16'b1101111111111000));
    mirror = 0;
    walk = 0;
`endif

    // Random mixed traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) walk = ~walk;
      if ($urandom_range(0, 29) == 0) begin
        xpos = 11'($urandom_range(0, 1100));
        ypos = 11'($urandom_range(0, 800));
      end
      mirror = 1'($urandom);
      h = xl_m + int'($urandom_range(0, 20)) - 2;
      v = yl_m + int'($urandom_range(0, 36)) - 2;
      if (h < 0) h = 0;
      if (v < 0) v = 0;
      step(h % 2048, v % 2048, 1'($urandom),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 19) == 0), 12'($urandom));
    end

    // Reset mid-frame
    #2 rst_n = 1'b0;
    #1 check_zero("midreset");
    for (int i = 0; i < 3; i++) begin
      rand_in();
      @(posedge pclk); #1;
      check_zero("midreset_hold");
    end
    walk = 0; xpos = 11'd400; ypos = 11'd300;
    @(negedge pclk); rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 16; i++)
      step(i, 5, 0, 0, 0, 0, 12'h0A0);
    for (int i = 0; i < 16; i++)
      step(400 + i, 305, 0, 0, 0, 0, 12'h0A0);
    latch(400, 300);
    for (int i = 0; i < 16; i++)
      step(400 + i, 305, 0, 0, 0, 0, 12'h0A0);
    flush();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
